// File: rtl/drum_mem_ctrl.sv
// drum_mem_ctrl: magnetic-drum main store plus its access controller.
//
// The drum rotates continuously; a free-running (pos, phase) counter tracks which sector is
// under the head. A request (rising edge of read_enable / write_enable) is accepted only when
// idle, then waits until the addressed sector starts passing under the head. The transfer
// completes on the last phase of that sector, and mem_finish pulses for one cycle.
//
// Ports:
//   clk           clock, all logic on rising edge
//   resetn        synchronous, active-low reset (drum contents are not cleared)
//   read_enable   read request level
//   write_enable  write request level
//   select_addr   word address, sampled on accept
//   write_data    store data, sampled on accept
//   read_data     last word read, held until the next read completes
//   mem_finish    one-cycle transfer-complete pulse
//   busy          controller not idle
//   drum_pos      sector currently under the head
//   drum_phase    cycle within the current sector
//   protocol_err  sticky: request edge arrived while busy, or read and write edges together
module drum_mem_ctrl #(
  parameter int unsigned WORD_W        = 31,
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned SECTOR_CYCLES = 4
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             read_enable,
  input  logic                             write_enable,
  input  logic [ADDR_W-1:0]                select_addr,
  input  logic [WORD_W-1:0]                write_data,
  output logic [WORD_W-1:0]                read_data,
  output logic                             mem_finish,
  output logic                             busy,
  output logic [ADDR_W-1:0]                drum_pos,
  output logic [$clog2(SECTOR_CYCLES)-1:0] drum_phase,
  output logic                             protocol_err
);

  localparam int unsigned PhaseW = $clog2(SECTOR_CYCLES);
  localparam int unsigned Words  = 2 ** ADDR_W;
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(SECTOR_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSeek, StXfer, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pos_q, pos_d;
  logic [PhaseW-1:0]   phase_q, phase_d;
  logic                rd_en_q, wr_en_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                op_wr_q, op_wr_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  logic                fin_q, fin_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic [WORD_W-1:0]   mem_q [Words];

  logic rd_rise, wr_rise, req, phase_wrap, mem_we;

  always_comb begin
    phase_wrap = (phase_q == PhaseLast);
    phase_d    = phase_wrap ? '0 : phase_q + PhaseW'(1);
    pos_d      = phase_wrap ? pos_q + ADDR_W'(1) : pos_q;

    rd_rise = read_enable & ~rd_en_q;
    wr_rise = write_enable & ~wr_en_q;
    req     = rd_rise | wr_rise;

    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    op_wr_d = op_wr_q;
    rdata_d = rdata_q;
    fin_d   = 1'b0;
    err_d   = err_q;
    mem_we  = 1'b0;

    // Simultaneous edges: the write is taken (op_wr_d = wr_rise), the read is dropped.
    if (rd_rise && wr_rise) err_d = 1'b1;
    if (req && state_q != StIdle) err_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          addr_d  = select_addr;
          data_d  = write_data;
          op_wr_d = wr_rise;
          state_d = (pos_q == select_addr && phase_q == '0) ? StXfer : StSeek;
        end
      end
      StSeek: begin
        if (pos_q == addr_q && phase_q == '0) state_d = StXfer;
      end
      StXfer: begin
        if (phase_wrap) begin
          // Reset in this cycle must abort the write, so gate the strobe with resetn.
          if (op_wr_q) mem_we = resetn;
          else         rdata_d = mem_q[addr_q];
          fin_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      pos_q   <= '0;
      phase_q <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      op_wr_q <= 1'b0;
      rdata_q <= '0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      phase_q <= phase_d;
      rd_en_q <= read_enable;
      wr_en_q <= write_enable;
      addr_q  <= addr_d;
      data_q  <= data_d;
      op_wr_q <= op_wr_d;
      rdata_q <= rdata_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Non-volatile store: no reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q] <= data_q;
  end

  assign read_data    = rdata_q;
  assign mem_finish   = fin_q;
  assign busy         = busy_q;
  assign drum_pos     = pos_q;
  assign drum_phase   = phase_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_drum_mem_ctrl.sv
// Directed self-checking bench for drum_mem_ctrl at default parameters.
// Cycle k = the clock period after the k-th rising edge following reset release.
module tb_drum_mem_ctrl;

  localparam int unsigned WordW = 31;
  localparam int unsigned AddrW = 10;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             read_enable = 1'b0;
  logic             write_enable = 1'b0;
  logic [AddrW-1:0] select_addr = '0;
  logic [WordW-1:0] write_data = '0;
  logic [WordW-1:0] read_data;
  logic             mem_finish;
  logic             busy;
  logic [AddrW-1:0] drum_pos;
  logic [1:0]       drum_phase;
  logic             protocol_err;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [WordW-1:0] Word2 = 31'h2AAA5555;
  localparam logic [WordW-1:0] Word5 = 31'h0055AA11;
  localparam logic [WordW-1:0] Word0 = 31'h1234567;

  always #5 clk = ~clk;

  drum_mem_ctrl #(
    .WORD_W       (WordW),
    .ADDR_W       (AddrW),
    .SECTOR_CYCLES(4)
  ) u_dut (
    .clk         (clk),
    .resetn      (resetn),
    .read_enable (read_enable),
    .write_enable(write_enable),
    .select_addr (select_addr),
    .write_data  (write_data),
    .read_data   (read_data),
    .mem_finish  (mem_finish),
    .busy        (busy),
    .drum_pos    (drum_pos),
    .drum_phase  (drum_phase),
    .protocol_err(protocol_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0.
  task automatic do_reset();
    resetn       = 1'b0;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  // Returns the cycle index at which mem_finish is seen, or -1 on timeout.
  task automatic wait_finish(input int start_cyc, input int limit, output int fin);
    int c;
    c   = start_cyc;
    fin = -1;
    for (int i = 0; i < limit; i++) begin
      if (mem_finish) begin
        fin = c;
        break;
      end
      step();
      c++;
    end
  endtask

  task automatic write_op(input logic [AddrW-1:0] a, input logic [WordW-1:0] d);
    int fin;
    write_enable = 1'b1;
    select_addr  = a;
    write_data   = d;
    step();
    write_enable = 1'b0;
    wait_finish(0, 5000, fin);
    check_eq("preload_done", 64'(fin >= 0), 64'd1);
    step();
  endtask

  initial begin
    int fin;
    int extra_fin;
    int busy_seen;

    // Reset state
    do_reset();
    check_eq("rst_pos", 64'(drum_pos), 64'd0);
    check_eq("rst_phase", 64'(drum_phase), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_finish", 64'(mem_finish), 64'd0);
    check_eq("rst_err", 64'(protocol_err), 64'd0);
    check_eq("rst_rdata", 64'(read_data), 64'd0);

    // Preload words used later; they must survive reset.
    write_op(10'd2, Word2);
    write_op(10'd5, Word5);

    // Write at cycle 0 to addr 0: transfer starts at once, finish at cycle 4.
    do_reset();
    write_enable = 1'b1;
    select_addr  = 10'd0;
    write_data   = Word0;
    step();
    write_enable = 1'b0;
    select_addr  = 10'd77;
    write_data   = '1;
    check_eq("t2_busy_c1", 64'(busy), 64'd1);
    step();
    step();
    check_eq("t2_phase_c3", 64'(drum_phase), 64'd3);
    check_eq("t2_finish_c3", 64'(mem_finish), 64'd0);
    wait_finish(3, 100, fin);
    check_eq("t2_fin_cycle", 64'(fin), 64'd4);
    step();
    read_enable = 1'b1;
    select_addr = 10'd0;
    step();
    read_enable = 1'b0;
    wait_finish(0, 5000, fin);
    check_eq("t2_readback", 64'(read_data), 64'(Word0));

    // Read rise at cycle 1, addr 2: finish at cycle 12.
    do_reset();
    step();
    read_enable = 1'b1;
    select_addr = 10'd2;
    step();
    read_enable = 1'b0;
    select_addr = 10'd9;
    wait_finish(2, 100, fin);
    check_eq("t1_fin_cycle", 64'(fin), 64'd12);
    check_eq("t1_rdata", 64'(read_data), 64'(Word2));
    check_eq("t1_pos_at_fin", 64'(drum_pos), 64'd3);
    step();
    check_eq("t1_busy_c13", 64'(busy), 64'd0);
    check_eq("t1_finish_c13", 64'(mem_finish), 64'd0);

    // Read rise at cycle 1, addr 0: sector missed, full revolution.
    do_reset();
    step();
    read_enable = 1'b1;
    select_addr = 10'd0;
    step();
    read_enable = 1'b0;
    wait_finish(2, 5000, fin);
    check_eq("t3_fin_cycle", 64'(fin), 64'd4100);
    check_eq("t3_rdata", 64'(read_data), 64'(Word0));

    // Held enable: exactly one access.
    step();
    read_enable = 1'b1;
    select_addr = 10'd5;
    step();
    wait_finish(0, 5000, fin);
    check_eq("t4_first_fin", 64'(fin >= 0), 64'd1);
    check_eq("t4_rdata", 64'(read_data), 64'(Word5));
    extra_fin = 0;
    busy_seen = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (mem_finish) extra_fin++;
      if (busy) busy_seen++;
    end
    check_eq("t4_extra_fin", 64'(extra_fin), 64'd0);
    check_eq("t4_busy_seen", 64'(busy_seen), 64'd0);
    check_eq("t4_err", 64'(protocol_err), 64'd0);
    read_enable = 1'b0;

    // Request edge during SEEK: sticky error, original read unaffected.
    do_reset();
    step();
    read_enable = 1'b1;
    select_addr = 10'd2;
    step();
    read_enable = 1'b0;
    step();
    read_enable = 1'b1;
    select_addr = 10'd7;
    step();
    read_enable = 1'b0;
    check_eq("t5_err_set", 64'(protocol_err), 64'd1);
    wait_finish(4, 100, fin);
    check_eq("t5_fin_cycle", 64'(fin), 64'd12);
    check_eq("t5_rdata", 64'(read_data), 64'(Word2));
    for (int i = 0; i < 5; i++) step();
    check_eq("t5_err_sticky", 64'(protocol_err), 64'd1);
    check_eq("t5_idle", 64'(busy), 64'd0);

    // Reset in the final XFER cycle of a write to addr 5: write aborted.
    do_reset();
    write_enable = 1'b1;
    select_addr  = 10'd5;
    write_data   = 31'h7FFFFFFF;
    step();
    write_enable = 1'b0;
    extra_fin = 0;
    for (int i = 1; i < 23; i++) begin
      if (mem_finish) extra_fin++;
      step();
    end
    check_eq("t6_busy_c23", 64'(busy), 64'd1);
    resetn = 1'b0;
    step();
    if (mem_finish) extra_fin++;
    step();
    if (mem_finish) extra_fin++;
    resetn = 1'b1;
    check_eq("t6_no_finish", 64'(extra_fin), 64'd0);
    check_eq("t6_pos", 64'(drum_pos), 64'd0);
    check_eq("t6_phase", 64'(drum_phase), 64'd0);
    check_eq("t6_busy", 64'(busy), 64'd0);
    read_enable = 1'b1;
    select_addr = 10'd5;
    step();
    read_enable = 1'b0;
    wait_finish(1, 100, fin);
    check_eq("t6_fin_cycle", 64'(fin), 64'd24);
    check_eq("t6_mem_kept", 64'(read_data), 64'(Word5));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
